// File: rtl/tie_cfg_pkg.sv
// Shared FSM encoding and frame-length helper for the tie-off bank.
// Optional parity bit in each frame is enabled by macro TIE_CFG_PARITY_EN.
package tie_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FULL   = 2'd2,
    LOCKED = 2'd3
  } state_e;

  function automatic int frame_len(input int width);
`ifdef TIE_CFG_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/tie_cfg_shreg.sv
// Shadow shift register with saturating bit counter and full/overrun flags.
// With TIE_CFG_PARITY_EN, a parity flop heads the chain and receives the last bit of the frame.
module tie_cfg_shreg
  import tie_cfg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(frame_len(WIDTH) + 2)
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic             shift_i,
  input  logic             clr_i,
  input  logic             si_i,
  output logic [WIDTH-1:0] data_o,
  output logic             par_ok_o,
  output logic             so_o,
  output logic             full_o,
  output logic             fill_o,
  output logic             overrun_o
);

  localparam int FL = frame_len(WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FL);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FL + 1);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             so_q, so_d;
  logic             head_bit;
  logic [WIDTH:0]   chain;

`ifdef TIE_CFG_PARITY_EN
  logic par_q, par_d;
  assign head_bit = par_q;
`else
  assign head_bit = si_i;
`endif

  assign chain = {head_bit, shadow_q};

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    so_d     = so_q;
`ifdef TIE_CFG_PARITY_EN
    par_d    = par_q;
`endif
    if (clr_i) begin
      cnt_d = '0;
    end else if (shift_i) begin
      so_d     = shadow_q[0];
      shadow_d = chain[WIDTH:1];
`ifdef TIE_CFG_PARITY_EN
      par_d    = si_i;
`endif
      if (cnt_q != CNT_OVR) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      so_q     <= 1'b0;
`ifdef TIE_CFG_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      so_q     <= so_d;
`ifdef TIE_CFG_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign data_o    = shadow_q;
  assign so_o      = so_q;
  assign full_o    = (cnt_q == CNT_FULL);
  assign overrun_o = (cnt_q == CNT_OVR);
  // A shift taken this cycle leaves the counter at or beyond a complete frame.
  assign fill_o    = (cnt_q >= CNT_FULL - CNT_W'(1));
`ifdef TIE_CFG_PARITY_EN
  assign par_ok_o  = (par_q == ^shadow_q);
`else
  assign par_ok_o  = 1'b1;
`endif

endmodule

// File: rtl/tie_cfg_bank.sv
// Reprogrammable tie-off bank: parameter reset value, serial shift/update override, lock until reset.
// Macro TIE_CFG_PARITY_EN appends an even-parity bit to each frame and rejects mismatching updates.
module tie_cfg_bank
  import tie_cfg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = $clog2(frame_len(WIDTH) + 2)
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic             se,
  input  logic             si,
  input  logic             upd,
  input  logic             lock,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             done,
  output logic             err,
  output logic             locked
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             locked_q;
  logic             shift, clr;
  logic [WIDTH-1:0] shadow;
  logic             par_ok, full, fill, overrun;

  tie_cfg_shreg #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_shreg (
    .ck       (ck),
    .nrst     (nrst),
    .shift_i  (shift),
    .clr_i    (clr),
    .si_i     (si),
    .data_o   (shadow),
    .par_ok_o (par_ok),
    .so_o     (so),
    .full_o   (full),
    .fill_o   (fill),
    .overrun_o(overrun)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    done_d  = 1'b0;
    err_d   = err_q;
    shift   = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE, SHIFT, FULL: begin
        if (se) begin
          // A shift always wins; an upd in the same cycle is only a protocol error.
          shift   = 1'b1;
          state_d = fill ? FULL : SHIFT;
          if (upd) err_d = 1'b1;
        end else if (state_q == IDLE) begin
          if (upd)  err_d   = 1'b1;
          if (lock) state_d = LOCKED;
        end else if (upd) begin
          clr     = 1'b1;
          state_d = IDLE;
          if (state_q == FULL && full && !overrun && par_ok) begin
            q_d    = shadow;
            done_d = 1'b1;
            err_d  = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (upd) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      q_q      <= RESET_VAL;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      done_q   <= done_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  assign q      = q_q;
  assign done   = done_q;
  assign err    = err_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_tie_cfg_bank.sv
// Directed bench for tie_cfg_bank (WIDTH=8, RESET_VAL=8'hA5); follows TIE_CFG_PARITY_EN when defined.
module tb_tie_cfg_bank;

  logic       ck = 1'b0;
  logic       nrst, se, si, upd, lock;
  logic [7:0] q;
  logic       so, done, err, locked;
  int         tests = 0;
  int         fails = 0;

`ifdef TIE_CFG_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  always #5 ck = ~ck;

  tie_cfg_bank #(
    .WIDTH    (8),
    .RESET_VAL(8'hA5)
  ) dut (
    .ck    (ck),
    .nrst  (nrst),
    .se    (se),
    .si    (si),
    .upd   (upd),
    .lock  (lock),
    .q     (q),
    .so    (so),
    .done  (done),
    .err   (err),
    .locked(locked)
  );

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    se = 1'b1;
    si = b;
    step();
    se = 1'b0;
    si = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d);
    for (int i = 0; i < 8; i++) shift_bit(d[i]);
`ifdef TIE_CFG_PARITY_EN
    shift_bit(^d);
`endif
  endtask

  task automatic pulse_upd();
    upd = 1'b1;
    step();
    upd = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    step();
    step();
    nrst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    se = 0; si = 0; upd = 0; lock = 0;
    do_reset();
    tests++; if (q !== 8'hA5) begin fails++; $display("FAIL reset_q: got %h want a5", q); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (so !== 1'b0) begin fails++; $display("FAIL reset_so: got %b want 0", so); end
  endtask

  task automatic test_normal_load();
    send_frame(8'h3C);
    tests++; if (q !== 8'hA5) begin fails++; $display("FAIL load_pre_q: got %h want a5", q); end
    pulse_upd();
    tests++; if (q !== 8'h3C) begin fails++; $display("FAIL load_q: got %h want 3c", q); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL load_done: got %b want 1", done); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL load_err: got %b want 0", err); end
    step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL load_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_short_frame();
    // Shadow holds 8'h3C, so the third shift presents its bit 2 on so.
    for (int i = 0; i < 3; i++) shift_bit(1'b1);
    tests++; if (so !== 1'b1) begin fails++; $display("FAIL short_so: got %b want 1", so); end
    for (int i = 0; i < 2; i++) shift_bit(1'b1);
    pulse_upd();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL short_err: got %b want 1", err); end
    tests++; if (q !== 8'h3C) begin fails++; $display("FAIL short_q: got %h want 3c", q); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL short_done: got %b want 0", done); end
    send_frame(8'hFF);
    pulse_upd();
    tests++; if (q !== 8'hFF) begin fails++; $display("FAIL reload_q: got %h want ff", q); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reload_err: got %b want 0", err); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL reload_done: got %b want 1", done); end
  endtask

  task automatic test_overrun_collision();
    logic [7:0] d;
    for (int i = 0; i < FL + 1; i++) shift_bit(1'b1);
    pulse_upd();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL overrun_err: got %b want 1", err); end
    tests++; if (q !== 8'hFF) begin fails++; $display("FAIL overrun_q: got %h want ff", q); end
    send_frame(8'h81);
    pulse_upd();
    tests++; if (q !== 8'h81) begin fails++; $display("FAIL clear_q: got %h want 81", q); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL clear_err: got %b want 0", err); end
    // Collision cycle carries bit 0 of the next frame; completing it proves the shift happened.
    d = 8'h5A;
    se = 1'b1; si = d[0]; upd = 1'b1;
    step();
    se = 1'b0; si = 1'b0; upd = 1'b0;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL collide_err: got %b want 1", err); end
    tests++; if (q !== 8'h81) begin fails++; $display("FAIL collide_q: got %h want 81", q); end
    for (int i = 1; i < 8; i++) shift_bit(d[i]);
`ifdef TIE_CFG_PARITY_EN
    shift_bit(1'b0);
`endif
    pulse_upd();
    tests++; if (q !== 8'h5A) begin fails++; $display("FAIL collide_frame_q: got %h want 5a", q); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL collide_frame_err: got %b want 0", err); end
  endtask

  task automatic test_lock();
    lock = 1'b1;
    step();
    lock = 1'b0;
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_locked: got %b want 1", locked); end
    send_frame(8'h12);
    pulse_upd();
    tests++; if (q !== 8'h5A) begin fails++; $display("FAIL lock_q: got %h want 5a", q); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL lock_err: got %b want 1", err); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_hold: got %b want 1", locked); end
    do_reset();
    tests++; if (q !== 8'hA5) begin fails++; $display("FAIL unlock_q: got %h want a5", q); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL unlock_locked: got %b want 0", locked); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL unlock_err: got %b want 0", err); end
  endtask

`ifdef TIE_CFG_PARITY_EN
  task automatic test_parity();
    logic [7:0] d;
    d = 8'h07;
    send_frame(d);
    pulse_upd();
    tests++; if (q !== 8'h07) begin fails++; $display("FAIL parity_good_q: got %h want 07", q); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL parity_good_err: got %b want 0", err); end
    for (int i = 0; i < 8; i++) shift_bit(d[i]);
    shift_bit(1'b0);
    pulse_upd();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL parity_bad_err: got %b want 1", err); end
    tests++; if (q !== 8'h07) begin fails++; $display("FAIL parity_bad_q: got %h want 07", q); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL parity_bad_done: got %b want 0", done); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    send_frame(8'h3C);
    pulse_upd();
    tests++; if (q !== 8'h3C) begin fails++; $display("FAIL midrst_pre_q: got %h want 3c", q); end
    for (int i = 0; i < 3; i++) shift_bit(1'b1);
    #2;
    nrst = 1'b0;
    #1;
    tests++; if (q !== 8'hA5) begin fails++; $display("FAIL midrst_async_q: got %h want a5", q); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL midrst_err: got %b want 0", err); end
    step();
    nrst = 1'b1;
    step();
    send_frame(8'h66);
    pulse_upd();
    tests++; if (q !== 8'h66) begin fails++; $display("FAIL midrst_frame_q: got %h want 66", q); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL midrst_frame_err: got %b want 0", err); end
  endtask

  initial begin
    nrst = 1'b0; se = 1'b0; si = 1'b0; upd = 1'b0; lock = 1'b0;
    test_reset();
    test_normal_load();
    test_short_frame();
    test_overrun_collision();
    test_lock();
`ifdef TIE_CFG_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
